ifu_fetch_ctrl: RTL and testbench

Instruction-fetch controller that owns the architectural PC register and drives the PC input of the next-PC logic (npc). It consumes npc's NPC output and fetches over a req/gnt/rvalid instruction-memory interface. It holds each instruction stable for the datapath until the datapath signals completion. It also splits out the imm16 and Target fields that npc consumes.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_fetch_ctrl_pc_reg.sv | 29 ++
 rtl/ifu_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifu_pkg;

  localparam int unsigned PC_W      = 30;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned IMM16_LSB = 0;
  localparam int unsigned IMM16_W   = 16;
  localparam int unsigned TARGET_W  = 26;

  // Word address of byte 0x0000_3000.
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 30'h0000_0C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_e;

endpackage

// File: rtl/ifu_fetch_ctrl_pc_reg.sv
// Architectural PC register: synchronous reset to RESET_PC, loads on load_i.
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  assign pc_d = load_i ? pc_i : pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches over req/gnt/rvalid and
// holds each instruction for the datapath until ex_done.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_W-1:0]     npc_in,
  output logic [PC_W-1:0]     pc_out,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INST_W-1:0]   imem_rdata,
  output logic                inst_valid,
  output logic [INST_W-1:0]   inst_out,
  output logic [IMM16_W-1:0]  imm16_out,
  output logic [TARGET_W-1:0] target_out,
  input  logic                ex_done,
  input  logic                stall,
  output logic [CNT_W-1:0]    retired
);

  state_e              state_q, state_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                req_pend_q, req_pend_d;
  logic                req_c;
  logic                pc_load_c;
  logic [PC_W-1:0]     pc_q;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pc_load_c),
    .pc_i   (npc_in),
    .pc_o   (pc_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control. Once a request is presented and not yet
  // granted it is held even if stall rises, so req/addr stay stable.
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    retired_d    = retired_q;
    req_pend_d   = 1'b0;
    req_c        = 1'b0;
    pc_load_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        req_c      = !stall || req_pend_q;
        req_pend_d = req_c && !imem_gnt;
        if (req_c && imem_gnt) begin
          if (imem_rvalid) begin
            inst_d       = imem_rdata;
            inst_valid_d = 1'b1;
            state_d      = VALID;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = VALID;
        end
      end
      VALID: begin
        if (ex_done) begin
          pc_load_c    = 1'b1;
          retired_d    = retired_q + CNT_W'(1);
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Instruction, valid flag, retire counter and pending-request flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      retired_q    <= '0;
      req_pend_q   <= 1'b0;
    end else begin
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      retired_q    <= retired_d;
      req_pend_q   <= req_pend_d;
    end
  end

  assign pc_out     = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = req_c;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_q;
  assign imm16_out  = inst_q[IMM16_LSB +: IMM16_W];
  assign target_out = inst_q[TARGET_W-1:0];
  assign retired    = retired_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: scenario tasks with a fetch scoreboard.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] npc_in;
  logic [29:0] pc_out;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [15:0] imm16_out;
  logic [25:0] target_out;
  logic        ex_done;
  logic        stall;
  logic [31:0] retired;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        exp_e;
  logic [29:0] exp_pc;
  logic [31:0] exp_ret;
  int          checks   = 0;
  int          failures = 0;

  ifu_fetch_ctrl #(
    .RESET_PC (30'h0000_0C00),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .npc_in      (npc_in),
    .pc_out      (pc_out),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .imm16_out   (imm16_out),
    .target_out  (target_out),
    .ex_done     (ex_done),
    .stall       (stall),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; npc_in = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; ex_done = 1'b0; stall = 1'b0;
    repeat (3) tick();
    exp_pc = 30'h0C00; exp_ret = '0;
    checks++; if (pc_out !== exp_pc) begin failures++; $display("FAIL reset_pc: got %h want %h", pc_out, exp_pc); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h want 0", inst_out); end
    checks++; if (retired !== 32'h0) begin failures++; $display("FAIL reset_retired: got %0d want 0", retired); end
  endtask

  task automatic test_zero_wait();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL first_cycle_req: got %b want 0", imem_req); end
    tick();
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0004;
    sb_q.push_back('{pc: exp_pc, inst: imem_rdata});
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 30'h0C00) begin failures++; $display("FAIL zw_addr: got %h want %h", imem_addr, 30'h0C00); end
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    exp_e = sb_q.pop_front();
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL zw_valid: got %b want 1", inst_valid); end
    checks++; if (inst_out !== exp_e.inst) begin failures++; $display("FAIL zw_inst: got %h want %h", inst_out, exp_e.inst); end
    checks++; if (pc_out !== exp_e.pc) begin failures++; $display("FAIL zw_pc: got %h want %h", pc_out, exp_e.pc); end
  endtask

  task automatic test_hold_and_retire();
    for (int i = 0; i < 3; i++) begin
      checks++; if (inst_out !== 32'h1000_0004) begin failures++; $display("FAIL hold_inst[%0d]: got %h want 10000004", i, inst_out); end
      checks++; if (imm16_out !== 16'h0004) begin failures++; $display("FAIL hold_imm16[%0d]: got %h want 0004", i, imm16_out); end
      checks++; if (target_out !== 26'h000_0004) begin failures++; $display("FAIL hold_target[%0d]: got %h want 0000004", i, target_out); end
      checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin failures++; $display("FAIL hold_ctrl[%0d]: got req=%b valid=%b want req=0 valid=1", i, imem_req, inst_valid); end
      tick();
    end
    ex_done = 1'b1; npc_in = 30'h0C05;
    tick();
    ex_done = 1'b0; npc_in = 30'h1234;
    exp_pc = 30'h0C05; exp_ret = exp_ret + 32'd1;
    #1;
    checks++; if (pc_out !== exp_pc) begin failures++; $display("FAIL retire_pc: got %h want %h", pc_out, exp_pc); end
    checks++; if (retired !== exp_ret) begin failures++; $display("FAIL retire_cnt: got %0d want %0d", retired, exp_ret); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL retire_valid: got %b want 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL retire_next_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc); end
  endtask

  task automatic test_delayed_gnt();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL ungranted[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp_pc); end
      checks++; if (pc_out !== exp_pc) begin failures++; $display("FAIL ungranted_pc[%0d]: got %h want %h", i, pc_out, exp_pc); end
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL wait_state[%0d]: got req=%b valid=%b want 0 0", i, imem_req, inst_valid); end
      tick();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h0C00_0123;
    sb_q.push_back('{pc: exp_pc, inst: imem_rdata});
    tick();
    imem_rvalid = 1'b0;
    #1;
    exp_e = sb_q.pop_front();
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL wait_valid: got %b want 1", inst_valid); end
    checks++; if (inst_out !== exp_e.inst || pc_out !== exp_e.pc) begin failures++; $display("FAIL wait_data: got inst=%h pc=%h want inst=%h pc=%h", inst_out, pc_out, exp_e.inst, exp_e.pc); end
  endtask

  task automatic test_stall();
    ex_done = 1'b1; npc_in = 30'h0C10; stall = 1'b1;
    tick();
    ex_done = 1'b0;
    exp_pc = 30'h0C10; exp_ret = exp_ret + 32'd1;
    #1;
    checks++; if (pc_out !== exp_pc || retired !== exp_ret) begin failures++; $display("FAIL stall_retire: got pc=%h ret=%0d want pc=%h ret=%0d", pc_out, retired, exp_pc, exp_ret); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
      if (i < 3) tick();
    end
    @(posedge clk); #2;
    stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL stall_release: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; stall = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_wait_req: got %b want 0", imem_req); end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2000_00AA;
    sb_q.push_back('{pc: exp_pc, inst: imem_rdata});
    tick();
    imem_rvalid = 1'b0; stall = 1'b0;
    #1;
    exp_e = sb_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst_out !== exp_e.inst || pc_out !== exp_e.pc) begin failures++; $display("FAIL stall_wait_fetch: got valid=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst_out, pc_out, exp_e.inst, exp_e.pc); end
  endtask

  task automatic test_reset_in_wait();
    ex_done = 1'b1; npc_in = 30'h0C20;
    tick();
    ex_done = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; rst_n = 1'b0;
    tick();
    tick();
    exp_pc = 30'h0C00; exp_ret = '0;
    checks++; if (pc_out !== exp_pc || retired !== exp_ret) begin failures++; $display("FAIL midreset_state: got pc=%h ret=%0d want pc=%h ret=0", pc_out, retired, exp_pc); end
    checks++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || imem_req !== 1'b0) begin failures++; $display("FAIL midreset_outputs: got valid=%b inst=%h req=%b want 0 0 0", inst_valid, inst_out, imem_req); end
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL stale_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc); end
    tick();
    imem_rvalid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst_out !== 32'h0) begin failures++; $display("FAIL stale_capture: got valid=%b inst=%h want 0 0", inst_valid, inst_out); end
    checks++; if (pc_out !== exp_pc || retired !== exp_ret) begin failures++; $display("FAIL stale_state: got pc=%h ret=%0d want pc=%h ret=0", pc_out, retired, exp_pc); end
  endtask

  task automatic test_stray_signals();
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h2000_0008;
    sb_q.push_back('{pc: exp_pc, inst: imem_rdata});
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    exp_e = sb_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst_out !== exp_e.inst || pc_out !== exp_e.pc) begin failures++; $display("FAIL stray_setup: got valid=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst_out, pc_out, exp_e.inst, exp_e.pc); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    #1;
    checks++; if (inst_out !== 32'h2000_0008 || inst_valid !== 1'b1) begin failures++; $display("FAIL stray_rvalid: got inst=%h valid=%b want 20000008 1", inst_out, inst_valid); end
    checks++; if (imm16_out !== 16'h0008) begin failures++; $display("FAIL stray_imm16: got %h want 0008", imm16_out); end
    ex_done = 1'b1; npc_in = 30'h0C30;
    tick();
    exp_pc = 30'h0C30; exp_ret = exp_ret + 32'd1;
    npc_in = 30'h3FFF_FFFF;
    tick();
    ex_done = 1'b0;
    #1;
    checks++; if (pc_out !== exp_pc || retired !== exp_ret) begin failures++; $display("FAIL exdone_in_req: got pc=%h ret=%0d want pc=%h ret=%0d", pc_out, retired, exp_pc, exp_ret); end
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL exdone_in_req_ctrl: got valid=%b req=%b want 0 1", inst_valid, imem_req); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] npcs [4];
    npcs[0] = 30'h3FFF_FFFF; npcs[1] = 30'h0000_0000;
    npcs[2] = 30'h0000_0001; npcs[3] = 30'h2AAA_5555;
    for (int i = 0; i < 4; i++) begin
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = $urandom;
      sb_q.push_back('{pc: exp_pc, inst: imem_rdata});
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      ex_done = 1'b1; npc_in = npcs[i];
      #1;
      exp_e = sb_q.pop_front();
      checks++; if (inst_valid !== 1'b1 || inst_out !== exp_e.inst || pc_out !== exp_e.pc) begin failures++; $display("FAIL b2b_fetch[%0d]: got valid=%b inst=%h pc=%h want 1 %h %h", i, inst_valid, inst_out, pc_out, exp_e.inst, exp_e.pc); end
      checks++; if (target_out !== exp_e.inst[25:0]) begin failures++; $display("FAIL b2b_target[%0d]: got %h want %h", i, target_out, exp_e.inst[25:0]); end
      tick();
      ex_done = 1'b0;
      exp_pc = npcs[i]; exp_ret = exp_ret + 32'd1;
      #1;
      checks++; if (pc_out !== exp_pc || retired !== exp_ret) begin failures++; $display("FAIL b2b_retire[%0d]: got pc=%h ret=%0d want pc=%h ret=%0d", i, pc_out, retired, exp_pc, exp_ret); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL b2b_next_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_hold_and_retire();
    test_delayed_gnt();
    test_stall();
    test_reset_in_wait();
    test_stray_signals();
    test_back_to_back();
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
